// File: rtl/regfile_bank_p_if.sv
// Register-bank port bundle: read/write addressing, PC increment, soft-clear handshake.
`timescale 1ns/1ps
interface regfile_bank_p_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] addrA;
  logic [ADDR_W-1:0] addrB;
  logic [ADDR_W-1:0] addrW;
  logic [DATA_W-1:0] dataW;
  logic              WE;
  logic              pcInc;
  logic              clrReq;
  logic [DATA_W-1:0] outA;
  logic [DATA_W-1:0] outB;
  logic [DATA_W-1:0] pcOut;
  logic              busy;
  logic              clrDone;

  modport master (
    output addrA, addrB, addrW, dataW, WE, pcInc, clrReq,
    input  outA, outB, pcOut, busy, clrDone
  );

  modport slave (
    input  addrA, addrB, addrW, dataW, WE, pcInc, clrReq,
    output outA, outB, pcOut, busy, clrDone
  );
endinterface

// File: rtl/regfile_bank_p.sv
// Parametrised two-read/one-write register bank with auto-incrementing PC slot,
// optional write-through bypass and a one-register-per-cycle soft-clear sweep.
`timescale 1ns/1ps
module regfile_bank_p #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int PC_INDEX = 15,
  parameter int PC_INC   = 4,
  parameter int BYPASS   = 1
) (
  input  logic            CLK,
  input  logic            CLR,
  regfile_bank_p_if.slave bus
);
  localparam int unsigned       NREGS    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PC_ADDR  = ADDR_W'(PC_INDEX);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);
  localparam logic [DATA_W-1:0] PC_STEP  = DATA_W'(PC_INC);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t            state, stateNext;
  logic [ADDR_W-1:0] idx, idxNext;
  logic              doneNext;
  logic              clrDoneQ;
  logic [DATA_W-1:0] regs [NREGS];

  logic busyInt;
  logic writeEn;
  logic incEn;
  logic bypassA;
  logic bypassB;

  assign busyInt = (state == SWEEP);
  assign writeEn = bus.WE && !busyInt;
  // A same-cycle write to the PC slot takes priority over the increment.
  assign incEn   = bus.pcInc && !busyInt && !(bus.WE && (bus.addrW == PC_ADDR));
  assign bypassA = (BYPASS != 0) && writeEn && (bus.addrW == bus.addrA);
  assign bypassB = (BYPASS != 0) && writeEn && (bus.addrW == bus.addrB);

  always_comb begin
    bus.outA    = bypassA ? bus.dataW : regs[bus.addrA];
    bus.outB    = bypassB ? bus.dataW : regs[bus.addrB];
    bus.pcOut   = regs[PC_ADDR];
    bus.busy    = busyInt;
    bus.clrDone = clrDoneQ;
  end

  always_comb begin
    stateNext = state;
    idxNext   = idx;
    doneNext  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.clrReq) begin
          stateNext = SWEEP;
          idxNext   = '0;
        end
      end
      SWEEP: begin
        idxNext = idx + 1'b1;
        if (idx == LAST_IDX) begin
          stateNext = IDLE;
          doneNext  = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state    <= IDLE;
      idx      <= '0;
      clrDoneQ <= 1'b0;
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      state    <= stateNext;
      idx      <= idxNext;
      clrDoneQ <= doneNext;
      if (busyInt) begin
        regs[idx] <= '0;
      end else begin
        if (writeEn) begin
          regs[bus.addrW] <= bus.dataW;
        end
        if (incEn) begin
          regs[PC_ADDR] <= regs[PC_ADDR] + PC_STEP;
        end
      end
    end
  end
endmodule

// File: doc/regfile_bank_p.md
# regfile_bank_p

Parametrised general-purpose register bank for the ARMSIM datapath, generalising the fixed 16×32 two-read/one-write register file. Width and depth are parameters. The bank adds:
- an independent write address;
- optional write-through bypass on both read ports;
- a program-counter slot that auto-increments;
- a sequenced soft-clear engine that zeroes the bank one register per cycle.

It sits between the decode stage (read addresses) and the writeback stage (write port), and supplies the PC to fetch.

## Interface
Parameters
- DATA_W, 32: register width in bits.
- ADDR_W, 4: address width; the bank holds NREGS = 2**ADDR_W registers.
- PC_INDEX, 15: index of the program-counter register; must be < NREGS.
- PC_INC, 4: amount added to the PC on each increment, taken modulo 2**DATA_W.
- BYPASS, 1: 1 enables write-through forwarding on outA/outB; 0 disables it.

Ports
- CLK  in  1  clock; all state updates on the rising edge.
- CLR  in  1  reset, asynchronous, active-high.
- addrA  in  ADDR_W  read address, port A.
- addrB  in  ADDR_W  read address, port B.
- addrW  in  ADDR_W  write address.
- dataW  in  DATA_W  write data.
- WE  in  1  write enable, 1 = write.
- pcInc  in  1  increment R[PC_INDEX] by PC_INC this cycle.
- clrReq  in  1  request a soft clear sweep.
- outA  out  DATA_W  read data, port A.
- outB  out  DATA_W  read data, port B.
- pcOut  out  DATA_W  current R[PC_INDEX], unbypassed.
- busy  out  1  high while a sweep is in progress.
- clrDone  out  1  one-cycle pulse when a sweep completes.

## Operation
- Reads are combinational from the array.
- Bypass rule, when BYPASS=1, WE=1, busy=0 and addrW equals the read address: the port returns dataW.
- Otherwise each port returns R[addr]. pcOut never bypasses.
- Write: on a rising edge with WE=1 and busy=0, R[addrW] <= dataW.
- PC increment: on a rising edge with pcInc=1 and busy=0, R[PC_INDEX] <= R[PC_INDEX] + PC_INC, with the carry discarded.
- If WE=1 with addrW=PC_INDEX and pcInc=1 in the same cycle, the write wins and the increment is dropped.

Soft-clear FSM, two states, IDLE and SWEEP, with an internal counter idx of ADDR_W bits:
- IDLE, clrReq=1: go to SWEEP and set idx=0. Nothing is zeroed on this edge.
- SWEEP: each edge writes R[idx] <= 0 and increments idx.
- SWEEP, idx = NREGS-1: after writing the last register, return to IDLE and pulse clrDone for the following cycle.
- busy = 1 exactly while in SWEEP.
- While in SWEEP, WE, pcInc and clrReq are ignored; there is no queueing.
- clrReq held high in IDLE after a sweep starts a new sweep on the next edge.
- Bypass is suppressed while busy.

Reset, CLR=1:
- Immediately and asynchronously, all registers become 0, the FSM goes to IDLE, idx=0 and clrDone=0.
- With all addresses in range, outA, outB and pcOut read 0, and busy reads 0.
- CLR asserted mid-sweep aborts the sweep: no clrDone pulse, and the bank is all zeros.
- Behaviour resumes on the first rising edge after CLR deasserts.

## Timing
- Read latency is 0 cycles (combinational).
- A write is visible on the unbypassed path in the cycle after the edge; with BYPASS=1 it is visible in the same cycle.
- A sweep takes NREGS+1 edges from clrReq sampled to clrDone high: 1 edge to enter SWEEP, then NREGS edges to clear R0..R[NREGS-1].
- busy is high for NREGS cycles.
- clrDone is high for exactly 1 cycle, starting the cycle after busy falls.
- R[k] reads 0 from cycle k+2 after the clrReq edge; registers with higher index keep their old value until swept.
- The PC wraps from 2**DATA_W - PC_INC to 0 without a flag.

## Test plan
- Reset, then bypass: assert CLR mid-cycle → all outputs 0 asynchronously. Release CLR. Write R3 = 0xDEADBEEF with addrA=3 in the same cycle → outA = 0xDEADBEEF immediately (BYPASS=1). The next cycle outA is still 0xDEADBEEF with WE=0.
- Dual read: write R1=0x11 and R2=0x22. Set addrA=1, addrB=2 → outA=0x11, outB=0x22. Swap the addresses → the values swap. Read R0 on both ports → 0.
- PC: pcInc=1 for 3 cycles from 0 → pcOut=12. Write R15=0x100 with pcInc=1 → pcOut=0x100. Load 0xFFFFFFFC, then pcInc once → pcOut=0.
- Sweep: fill R0..R15 with i+1 and pulse clrReq. Check busy=1 for 16 cycles. Check R5 still reads 6 until the 7th cycle after the clrReq edge, then reads 0. A WE to R9 during the sweep is discarded. clrDone pulses once; afterwards all registers read 0.
- Abort: start a sweep and assert CLR after 4 cycles → busy=0 immediately, no clrDone, all registers 0. A new clrReq then runs a full-length sweep.
- Parametric: DATA_W=16, ADDR_W=3, PC_INDEX=7, PC_INC=2, BYPASS=0 → a same-cycle read of the written address returns the old value. The sweep lasts 8 busy cycles. PC wraps from 0xFFFE to 0.
